if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. It holds the PC, fetches from instruction memory over a req/ready handshake, and absorbs hazard stalls and EX-stage redirects. It presents the registered instruction, its PC and the decoded `opcode`/`func3`/`func7`/register fields directly to the decode-stage control unit and register file.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 39 +++
 rtl/if_stage.sv | 173 +++++++++++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline.
// Holds the default datapath width, reset PC and bubble encoding.
// Also holds the base opcode values and the fetch-state encoding used by if_stage.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load           capture {d_pc, d_inst} as a valid instruction
//   flush          insert a bubble (valid=0, inst=NOP); pc is left unchanged
//   d_pc, d_inst   incoming fetch PC and instruction
//   q_valid, q_pc, q_inst   registered IF/ID contents
// flush takes priority over load. With neither asserted the contents hold.
module if_id_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] d_pc,
    input  logic [31:0]     d_inst,
    output logic            q_valid,
    output logic [XLEN-1:0] q_pc,
    output logic [31:0]     q_inst
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_pc    <= '0;
            q_inst  <= NOP_INST;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_inst  <= NOP_INST;
        end else if (load) begin
            q_valid <= 1'b1;
            q_pc    <= d_pc;
            q_inst  <= d_inst;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with PC, imem req/ready handshake and IF/ID register.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   stall                     hold PC and IF/ID
//   redirect, redirect_pc     EX-stage redirect; redirect_pc[1:0] are ignored
//   imem_req, imem_addr       fetch request and address (stable until imem_ready)
//   imem_ready, imem_rdata    response strobe and instruction data
//   id_valid, id_pc, id_inst  registered IF/ID contents
//   opcode, func3, func7, id_rs1, id_rs2, id_rd   slices of id_inst
//
// state | meaning
// IDLE  | one cycle out of reset, no request
// FETCH | request at pc outstanding; each response advances or redirects
// DRAIN | redirect seen with a request in flight; wait for it, drop it, then jump
// HOLD  | response arrived under stall; parked in skid until stall drops
module if_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd
);

    import riscv_pkg::*;

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] pend_pc, pend_pc_n;
    logic [XLEN-1:0] skid_pc, skid_pc_n;
    logic [31:0]     skid_inst, skid_inst_n;

    logic            ifid_load;
    logic            ifid_flush;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_inst;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;
    logic            unused_target_lsbs;

    assign target             = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_target_lsbs = ^redirect_pc[1:0];
    assign pc_inc             = pc + XLEN'(4);

    // pc is not moved while draining, so the in-flight address stays on the bus.
    assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            pend_pc   <= '0;
            skid_pc   <= '0;
            skid_inst <= NOP_INST;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_pc   <= pend_pc_n;
            skid_pc   <= skid_pc_n;
            skid_inst <= skid_inst_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        skid_pc_n   = skid_pc;
        skid_inst_n = skid_inst;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_pc     = pc;
        ifid_inst   = imem_rdata;

        unique case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem_ready) begin
                        pc_n = target;
                    end else begin
                        pend_pc_n = target;
                        state_n   = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_n = pc_inc;
                    if (stall) begin
                        skid_pc_n   = pc;
                        skid_inst_n = imem_rdata;
                        state_n     = ST_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_n       = target;
                    ifid_flush = 1'b1;
                    state_n    = ST_FETCH;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    ifid_pc   = skid_pc;
                    ifid_inst = skid_inst;
                    state_n   = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                ifid_flush = 1'b1;
                if (redirect) begin
                    pend_pc_n = target;
                end
                if (imem_ready) begin
                    pc_n    = redirect ? target : pend_pc;
                    state_n = ST_FETCH;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    if_id_reg #(
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .d_pc    (ifid_pc),
        .d_inst  (ifid_inst),
        .q_valid (id_valid),
        .q_pc    (id_pc),
        .q_inst  (id_inst)
    );

    assign opcode = id_inst[6:0];
    assign func3  = id_inst[14:12];
    assign func7  = id_inst[31:25];
    assign id_rs1 = id_inst[19:15];
    assign id_rs2 = id_inst[24:20];
    assign id_rd  = id_inst[11:7];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_inst;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        rst2;
    logic        imem_req2, id_valid2;
    logic [31:0] imem_addr2, id_pc2, id_inst2;
    logic [6:0]  opcode2, func72;
    logic [2:0]  func32;
    logic [4:0]  id_rs12, id_rs22, id_rd2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .opcode(opcode), .func3(func3),
        .func7(func7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(1'b1), .imem_rdata(NOP),
        .id_valid(id_valid2), .id_pc(id_pc2), .id_inst(id_inst2), .opcode(opcode2), .func3(func32),
        .func7(func72), .id_rs1(id_rs12), .id_rs2(id_rs22), .id_rd(id_rd2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", id_inst, NOP); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", id_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    endtask

    task automatic test_fetch();
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL fetch0: got v=%b pc=%h want 1/0", id_valid, id_pc); end
        checks++; if (opcode !== 7'b0010011 || func7 !== 7'h0 || id_rd !== 5'd1 || id_rs1 !== 5'd0) begin
            errors++; $display("FAIL fields0: got op=%b f7=%h rd=%0d rs1=%0d want 0010011/0/1/0", opcode, func7, id_rd, id_rs1); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL addr4: got %h want 4", imem_addr); end
        imem_rdata = 32'h0020_8133;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== 32'h0020_8133) begin
            errors++; $display("FAIL fetch1: got v=%b pc=%h inst=%h want 1/4/00208133", id_valid, id_pc, id_inst); end
        checks++; if (opcode !== 7'b0110011 || func7 !== 7'h0 || func3 !== 3'd0 || id_rd !== 5'd2 || id_rs1 !== 5'd1 || id_rs2 !== 5'd2) begin
            errors++; $display("FAIL fields1: got op=%b f7=%h f3=%0d rd=%0d rs1=%0d rs2=%0d want 0110011/0/0/2/1/2",
                               opcode, func7, func3, id_rd, id_rs1, id_rs2); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL addr8: got %h want 8", imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0031_0193;
        tick();
        imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
        checks++; if (id_inst !== 32'h0020_8133 || id_pc !== 32'h4) begin
            errors++; $display("FAIL stall_frozen1: got inst=%h pc=%h want 00208133/4", id_inst, id_pc); end
        tick(); tick();
        checks++; if (id_inst !== 32'h0020_8133 || id_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_frozen3: got inst=%h v=%b req=%b want 00208133/1/0", id_inst, id_valid, imem_req); end
        stall = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_inst !== 32'h0031_0193) begin
            errors++; $display("FAIL skid_release: got v=%b pc=%h inst=%h want 1/8/00310193", id_valid, id_pc, id_inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL after_hold_addr: got req=%b addr=%h want 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_ready();
        redirect = 1'b1; redirect_pc = 32'h0000_0103; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        redirect = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin
            errors++; $display("FAIL redir_bubble: got v=%b inst=%h want 0/%h", id_valid, id_inst, NOP); end
        checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL redir_pc_kept: got %h want 8", id_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_addr: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
    endtask

    task automatic test_drain();
        imem_rdata = 32'h0000_0513;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
            errors++; $display("FAIL target_fetch: got v=%b pc=%h want 1/100", id_valid, id_pc); end
        redirect = 1'b1; redirect_pc = 32'h0000_0200; imem_ready = 1'b0;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h104 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
            errors++; $display("FAIL drain_enter: got addr=%h req=%b v=%b want 104/1/0", imem_addr, imem_req, id_valid); end
        tick();
        checks++; if (imem_addr !== 32'h104 || imem_req !== 1'b1) begin
            errors++; $display("FAIL drain_hold_addr: got addr=%h req=%b want 104/1", imem_addr, imem_req); end
        imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP || imem_addr !== 32'h200) begin
            errors++; $display("FAIL drain_exit: got v=%b inst=%h addr=%h want 0/%h/200", id_valid, id_inst, imem_addr, NOP); end
        imem_rdata = 32'h0000_0033;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'h0000_0033) begin
            errors++; $display("FAIL post_drain_fetch: got v=%b pc=%h inst=%h want 1/200/00000033", id_valid, id_pc, id_inst); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; imem_ready = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        redirect = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h300) begin
            errors++; $display("FAIL redir_stall_flush: got v=%b addr=%h want 0/300", id_valid, imem_addr); end
        imem_rdata = 32'h0000_0033;
        tick();
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
            errors++; $display("FAIL hold_bubble: got req=%b v=%b want 0/0", imem_req, id_valid); end
        redirect = 1'b1; redirect_pc = 32'h400; imem_ready = 1'b0;
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'h200) begin
            errors++; $display("FAIL hold_redir_flush: got v=%b inst=%h pc=%h want 0/%h/200", id_valid, id_inst, id_pc, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            errors++; $display("FAIL hold_redir_addr: got req=%b addr=%h want 1/400", imem_req, imem_addr); end
    endtask

    task automatic test_rst_drain();
        redirect = 1'b1; redirect_pc = 32'h500; imem_ready = 1'b0;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            errors++; $display("FAIL pre_rst_drain: got req=%b addr=%h want 1/400", imem_req, imem_addr); end
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
            errors++; $display("FAIL rst_in_drain: got req=%b v=%b pc=%h want 0/0/0", imem_req, id_valid, id_pc); end
        rst = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        rst2 = 1'b0;
        tick();
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", imem_req2, imem_addr2); end
        tick();
        checks++; if (imem_addr2 !== 32'h0 || id_pc2 !== 32'hFFFF_FFFC || id_valid2 !== 1'b1) begin
            errors++; $display("FAIL wrap_second: got addr=%h pc=%h v=%b want 0/fffffffc/1", imem_addr2, id_pc2, id_valid2); end
        tick();
        checks++; if (id_pc2 !== 32'h0 || imem_addr2 !== 32'h4) begin
            errors++; $display("FAIL wrap_third: got pc=%h addr=%h want 0/4", id_pc2, imem_addr2); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_ready();
        test_drain();
        test_redirect_stall();
        test_rst_drain();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
